alu_rs_scheduler: RTL
=====================

Name: alu_rs_scheduler

Overview:
Reservation station and issue scheduler feeding the single-cycle ALU in the out-of-order RV32I core. It accepts decoded ALU-class instructions (ARITH, ARITHI, BR, JAL, JALR, LUI, AUIPC) from the issue stage. It holds them until both source operands are ready, capturing operands from the ALU and LSB result broadcasts. Each cycle it dispatches at most one ready entry to the ALU through registered ALU input signals.

Parameters:
RS_SIZE, 16, number of entries (power of two, at least 2)
ROB_POS_W, 4, ROB index width
DATA_W, 32, operand, immediate and PC width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; when 0, no state change
rollback  in  1  flush all entries (mispredict)
issue_valid  in  1  write a new entry this cycle
issue_opcode  in  7  opcode
issue_funct3  in  3  funct3
issue_funct7  in  1  instr[30]
issue_rs1_rdy  in  1  rs1 value valid
issue_rs1_val  in  DATA_W  rs1 value
issue_rs1_rob  in  ROB_POS_W  producer tag when rs1 not ready
issue_rs2_rdy  in  1  rs2 value valid
issue_rs2_val  in  DATA_W  rs2 value
issue_rs2_rob  in  ROB_POS_W  producer tag when rs2 not ready
issue_imm  in  DATA_W  immediate
issue_pc  in  DATA_W  instruction PC
issue_rob_pos  in  ROB_POS_W  destination ROB slot
rs_full  out  1  no free entry
alu_res  in  1  ALU broadcast valid
alu_res_rob  in  ROB_POS_W  ALU broadcast tag
alu_res_val  in  DATA_W  ALU broadcast value
lsb_res  in  1  LSB broadcast valid
lsb_res_rob  in  ROB_POS_W  LSB broadcast tag
lsb_res_val  in  DATA_W  LSB broadcast value
alu_en  out  1  dispatch valid
alu_opcode  out  7  dispatched opcode
alu_funct3  out  3  dispatched funct3
alu_funct7  out  1  dispatched funct7
alu_val1  out  DATA_W  operand 1
alu_val2  out  DATA_W  operand 2
alu_imm  out  DATA_W  immediate
alu_pc  out  DATA_W  PC
alu_rob_pos  out  ROB_POS_W  destination ROB slot

Behaviour:
- Per-entry state: busy, rdy1/val1/q1, rdy2/val2/q2, opcode, funct3, funct7, imm, pc, rob_pos.
- Reset, or rollback with rdy: all busy=0; alu_en=0; every other alu_* output=0. Rollback overrides a same-cycle issue.
- rdy=0: all registers hold, including alu_en.
- rs_full: combinational, high when all entries are busy. It is computed from registered busy bits only; a same-cycle dispatch does not clear it.
- Issue: if issue_valid and a free entry exists, write the lowest-index free entry. If issue_valid while full, the instruction is dropped; the issuer must not do this.
- Same-cycle wakeup on issue: if rsN not ready and a valid broadcast carries the matching tag this cycle, the entry is written with rdyN=1 and the broadcast value. ALU broadcast has priority over LSB if both match.
- Wakeup of stored entries: each busy entry with rdyN=0 and qN equal to a valid broadcast tag sets rdyN=1 and captures the value in the same cycle.
- Opcodes LUI, AUIPC and JAL do not use rs1/rs2. The issuer passes rdy=1 for them; the RS does not special-case them.
- Select: among busy entries with rdy1 and rdy2 both set in registered state, pick the lowest index. On the next posedge: alu_en=1, alu_* outputs=entry fields, entry busy=0. If none is ready, alu_en=0 and the other alu_* outputs hold.
- Latency: an entry issued ready at edge E produces alu_en at edge E+1. An entry woken at edge E dispatches at E+1. There is no combinational bypass from issue or broadcast to select.
- Simultaneous issue and dispatch: allowed. The freed slot is reusable from the next cycle.
- alu_en is a one-cycle pulse per dispatched entry; the ALU sees each dispatch exactly once.

Optional Feature:
RS_OLDEST_FIRST_EN
- Defined: select picks the oldest ready entry. Each entry keeps an age counter, width log2(RS_SIZE)+1. On issue the counter is set to 0; each cycle with rdy, every busy entry with age below its maximum increments. The highest age wins; ties go to the lowest index. Rollback/reset clear all ages.
- Undefined: lowest-index selection as above; no age storage.

Test Plan:
- Issue ADDI (opcode 0010011, f3 000) with rs1 ready=5, imm=7, rob_pos=3 -> next cycle alu_en=1, alu_val1=5, alu_imm=7, alu_rob_pos=3; the cycle after, alu_en=0.
- Issue ADD with rs1 ready=10 and rs2 waiting on tag 6; then lsb_res=1, tag 6, value 0x20 -> alu_en one cycle after the broadcast, alu_val2=0x20.
- Issue with rs2 tag 2 in the same cycle as alu_res for tag 2, value 9 -> the entry is stored ready and dispatches the next cycle with val2=9.
- Fill 16 entries all waiting on tag 15 -> rs_full=1; broadcast tag 15 -> 16 consecutive alu_en pulses, rob_pos in index order, then rs_full=0.
- Fill 4 waiting entries, assert rollback -> next cycle alu_en=0, rs_full=0; a later broadcast of their tags causes no dispatch.
- Hold rdy=0 for 3 cycles with a ready entry present -> no new dispatch and entry still busy; rdy=1 -> it dispatches exactly once.

Source files
------------

// File: rtl/alu_rs_scheduler.sv
// Reservation station and issue scheduler for the single-cycle ALU.
// Holds ALU-class instructions until both operands are ready and captures
// operands from the ALU and LSB result broadcasts. At most one ready entry
// is dispatched per cycle through registered alu_* outputs.
// Optional build macro RS_OLDEST_FIRST_EN: select the oldest ready entry
// (per-entry saturating age) instead of the lowest-index ready entry.
module alu_rs_scheduler #(
  parameter int unsigned RS_SIZE   = 16,
  parameter int unsigned ROB_POS_W = 4,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rollback,
  input  logic                 issue_valid,
  input  logic [6:0]           issue_opcode,
  input  logic [2:0]           issue_funct3,
  input  logic                 issue_funct7,
  input  logic                 issue_rs1_rdy,
  input  logic [DATA_W-1:0]    issue_rs1_val,
  input  logic [ROB_POS_W-1:0] issue_rs1_rob,
  input  logic                 issue_rs2_rdy,
  input  logic [DATA_W-1:0]    issue_rs2_val,
  input  logic [ROB_POS_W-1:0] issue_rs2_rob,
  input  logic [DATA_W-1:0]    issue_imm,
  input  logic [DATA_W-1:0]    issue_pc,
  input  logic [ROB_POS_W-1:0] issue_rob_pos,
  output logic                 rs_full,
  input  logic                 alu_res,
  input  logic [ROB_POS_W-1:0] alu_res_rob,
  input  logic [DATA_W-1:0]    alu_res_val,
  input  logic                 lsb_res,
  input  logic [ROB_POS_W-1:0] lsb_res_rob,
  input  logic [DATA_W-1:0]    lsb_res_val,
  output logic                 alu_en,
  output logic [6:0]           alu_opcode,
  output logic [2:0]           alu_funct3,
  output logic                 alu_funct7,
  output logic [DATA_W-1:0]    alu_val1,
  output logic [DATA_W-1:0]    alu_val2,
  output logic [DATA_W-1:0]    alu_imm,
  output logic [DATA_W-1:0]    alu_pc,
  output logic [ROB_POS_W-1:0] alu_rob_pos
);

  localparam int unsigned IdxW = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0]   busy_q, rdy1_q, rdy2_q;
  logic [DATA_W-1:0]    val1_q   [RS_SIZE];
  logic [DATA_W-1:0]    val2_q   [RS_SIZE];
  logic [ROB_POS_W-1:0] q1_q     [RS_SIZE];
  logic [ROB_POS_W-1:0] q2_q     [RS_SIZE];
  logic [6:0]           opcode_q [RS_SIZE];
  logic [2:0]           funct3_q [RS_SIZE];
  logic [RS_SIZE-1:0]   funct7_q;
  logic [DATA_W-1:0]    imm_q    [RS_SIZE];
  logic [DATA_W-1:0]    pc_q     [RS_SIZE];
  logic [ROB_POS_W-1:0] rob_q    [RS_SIZE];

`ifdef RS_OLDEST_FIRST_EN
  localparam int unsigned AgeW = IdxW + 1;
  logic [AgeW-1:0] age_q [RS_SIZE];
  logic [AgeW-1:0] best_age;
`endif

  logic            free_found, sel_found;
  logic [IdxW-1:0] free_idx, sel_idx;
  logic            iss_rdy1, iss_rdy2;
  logic [DATA_W-1:0] iss_val1, iss_val2;

  // Full is taken from registered busy bits only; a same-cycle dispatch does not clear it.
  assign rs_full = &busy_q;

  // Lowest-index free slot for the incoming instruction.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = IdxW'(i);
      end
    end
  end

  // Pick the entry to dispatch from registered state (no bypass from issue/broadcast).
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
`ifdef RS_OLDEST_FIRST_EN
    best_age  = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      // Strict compare keeps the lowest index on equal ages.
      if (busy_q[i] && rdy1_q[i] && rdy2_q[i] && (!sel_found || age_q[i] > best_age)) begin
        sel_found = 1'b1;
        sel_idx   = IdxW'(i);
        best_age  = age_q[i];
      end
    end
`else
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (busy_q[i] && rdy1_q[i] && rdy2_q[i]) begin
        sel_found = 1'b1;
        sel_idx   = IdxW'(i);
      end
    end
`endif
  end

  // Resolve issuing operands against this cycle's broadcasts; ALU wins over LSB.
  always_comb begin
    iss_rdy1 = issue_rs1_rdy;
    iss_val1 = issue_rs1_val;
    iss_rdy2 = issue_rs2_rdy;
    iss_val2 = issue_rs2_val;
    if (!issue_rs1_rdy) begin
      if (alu_res && alu_res_rob == issue_rs1_rob) begin
        iss_rdy1 = 1'b1;
        iss_val1 = alu_res_val;
      end else if (lsb_res && lsb_res_rob == issue_rs1_rob) begin
        iss_rdy1 = 1'b1;
        iss_val1 = lsb_res_val;
      end
    end
    if (!issue_rs2_rdy) begin
      if (alu_res && alu_res_rob == issue_rs2_rob) begin
        iss_rdy2 = 1'b1;
        iss_val2 = alu_res_val;
      end else if (lsb_res && lsb_res_rob == issue_rs2_rob) begin
        iss_rdy2 = 1'b1;
        iss_val2 = lsb_res_val;
      end
    end
  end

  // Entry state, wakeup, dispatch and issue.
  always_ff @(posedge clk) begin
    if (rst || (rdy && rollback)) begin
      busy_q      <= '0;
      rdy1_q      <= '0;
      rdy2_q      <= '0;
      alu_en      <= 1'b0;
      alu_opcode  <= '0;
      alu_funct3  <= '0;
      alu_funct7  <= 1'b0;
      alu_val1    <= '0;
      alu_val2    <= '0;
      alu_imm     <= '0;
      alu_pc      <= '0;
      alu_rob_pos <= '0;
`ifdef RS_OLDEST_FIRST_EN
      for (int i = 0; i < RS_SIZE; i++) age_q[i] <= '0;
`endif
    end else if (rdy) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy_q[i]) begin
          if (!rdy1_q[i]) begin
            if (alu_res && alu_res_rob == q1_q[i]) begin
              rdy1_q[i] <= 1'b1;
              val1_q[i] <= alu_res_val;
            end else if (lsb_res && lsb_res_rob == q1_q[i]) begin
              rdy1_q[i] <= 1'b1;
              val1_q[i] <= lsb_res_val;
            end
          end
          if (!rdy2_q[i]) begin
            if (alu_res && alu_res_rob == q2_q[i]) begin
              rdy2_q[i] <= 1'b1;
              val2_q[i] <= alu_res_val;
            end else if (lsb_res && lsb_res_rob == q2_q[i]) begin
              rdy2_q[i] <= 1'b1;
              val2_q[i] <= lsb_res_val;
            end
          end
`ifdef RS_OLDEST_FIRST_EN
          if (age_q[i] != '1) age_q[i] <= age_q[i] + AgeW'(1);
`endif
        end
      end

      alu_en <= sel_found;
      if (sel_found) begin
        busy_q[sel_idx] <= 1'b0;
        alu_opcode      <= opcode_q[sel_idx];
        alu_funct3      <= funct3_q[sel_idx];
        alu_funct7      <= funct7_q[sel_idx];
        alu_val1        <= val1_q[sel_idx];
        alu_val2        <= val2_q[sel_idx];
        alu_imm         <= imm_q[sel_idx];
        alu_pc          <= pc_q[sel_idx];
        alu_rob_pos     <= rob_q[sel_idx];
      end

      // The free slot is never the selected one, so these writes never collide.
      if (issue_valid && free_found) begin
        busy_q[free_idx]   <= 1'b1;
        rdy1_q[free_idx]   <= iss_rdy1;
        val1_q[free_idx]   <= iss_val1;
        q1_q[free_idx]     <= issue_rs1_rob;
        rdy2_q[free_idx]   <= iss_rdy2;
        val2_q[free_idx]   <= iss_val2;
        q2_q[free_idx]     <= issue_rs2_rob;
        opcode_q[free_idx] <= issue_opcode;
        funct3_q[free_idx] <= issue_funct3;
        funct7_q[free_idx] <= issue_funct7;
        imm_q[free_idx]    <= issue_imm;
        pc_q[free_idx]     <= issue_pc;
        rob_q[free_idx]    <= issue_rob_pos;
`ifdef RS_OLDEST_FIRST_EN
        age_q[free_idx]    <= '0;
`endif
      end
    end
  end

endmodule
